// File: rtl/spi_rdid_slave.sv
// SPI mode-0 slave answering RDID (0x9F) with a repeating 3-byte JEDEC ID.
// All SPI pins are synchronized into clk; SPICLK edges are detected, never used as a clock.
module spi_rdid_slave #(
  parameter logic [7:0] MANUF_ID = 8'h20,
  parameter logic [7:0] MEM_TYPE = 8'h20,
  parameter logic [7:0] MEM_CAP  = 8'h15,
  parameter logic [7:0] RDID_OP  = 8'h9F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPICS_N,
  input  logic       SPIMOSI,
  output logic       SPIMISO,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic       rdid_done
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned ID_W  = 24;
  localparam logic [ID_W-1:0] ID = {MANUF_ID, MEM_TYPE, MEM_CAP};

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [7:0]        opcode_sr, opcode_sr_n;
  logic [ID_W-1:0]   id_sr, id_sr_n;
  logic              miso_n;
  logic [7:0]        opcode_n;
  logic              opcode_valid_n, rdid_done_n;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall;

  // Two-flop synchronizers plus a registered SPICLK copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= SPICLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= SPICS_N;
      cs_s2   <= cs_s1;
      mosi_s1 <= SPIMOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      opcode_sr    <= '0;
      id_sr        <= '0;
      SPIMISO      <= 1'b0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
      rdid_done    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      opcode_sr    <= opcode_sr_n;
      id_sr        <= id_sr_n;
      SPIMISO      <= miso_n;
      opcode       <= opcode_n;
      opcode_valid <= opcode_valid_n;
      rdid_done    <= rdid_done_n;
    end
  end

  // Next-state and next-output logic; chip-select deassertion overrides everything
  always_comb begin
    state_n        = state;
    bit_cnt_n      = bit_cnt;
    opcode_sr_n    = opcode_sr;
    id_sr_n        = id_sr;
    miso_n         = SPIMISO;
    opcode_n       = opcode;
    opcode_valid_n = 1'b0;
    rdid_done_n    = 1'b0;

    if (cs_s2) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      opcode_sr_n = '0;
      miso_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_n    = 1'b0;
          bit_cnt_n = '0;
          state_n   = CMD;
        end
        CMD: begin
          if (sclk_rise) begin
            opcode_sr_n = {opcode_sr[6:0], mosi_s2};
            if (bit_cnt == CNT_W'(7)) begin
              opcode_n       = opcode_sr_n;
              opcode_valid_n = 1'b1;
              bit_cnt_n      = '0;
              if (opcode_sr_n == RDID_OP) begin
                id_sr_n = ID;
                state_n = RESP;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (sclk_fall) begin
            miso_n  = id_sr[ID_W-1];
            id_sr_n = {id_sr[ID_W-2:0], 1'b0};
          end
          // 24th response rise: ID fully shifted, reload so it repeats seamlessly
          if (sclk_rise) begin
            if (bit_cnt == CNT_W'(ID_W - 1)) begin
              bit_cnt_n   = '0;
              rdid_done_n = 1'b1;
              id_sr_n     = ID;
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        IGNORE: begin
          miso_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          miso_n  = 1'b0;
        end
      endcase
    end
  end

endmodule
